pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, a synchronous flush and a stall counter. It replaces the fixed IF/ID register between fetch and decode. It carries `pc4` and the instruction word as a payload, and is sized by parameter so the same block can later serve ID/EX and EX/MEM. Invalid slots present a NOP, so decode sees a bubble exactly as it does after reset.

## Interface
- `PC_W`, 32: width of the `pc4` field.
- `INST_W`, 32: width of the instruction field.
- `NOP_INST`, 0: instruction value driven whenever `out_valid` = 0.
- `CNT_W`, 16: width of the stall counter.

Ports (name, direction, width, meaning):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has a beat.
- `in_ready`  out  1  stage can accept a beat; registered.
- `in_pc4`  in  PC_W  upstream PC+4.
- `in_inst`  in  INST_W  upstream instruction.
- `flush`  in  1  synchronous kill of all held and incoming beats.
- `out_valid`  out  1  `out_pc4` / `out_inst` hold a live beat.
- `out_ready`  in  1  downstream consumes the beat this cycle.
- `out_pc4`  out  PC_W  held PC+4.
- `out_inst`  out  INST_W  held instruction, or `NOP_INST` when invalid.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid` & ~`out_ready`.

## Operation
- Handshake rules:
  - An upstream beat is accepted when `in_valid` & `in_ready`.
  - A downstream beat is taken when `out_valid` & `out_ready`.
  - `in_valid` may rise while `in_ready` = 0; no beat is lost or duplicated.
- Storage is two entries: `main`, which drives the outputs, and `skid`.
- The state machine has three states:
  - EMPTY: `out_valid` = 0, `in_ready` = 1.
  - ONE: `main` full, `in_ready` = 1.
  - TWO: both entries full, `in_ready` = 0.
- Transitions when `flush` = 0:
  - EMPTY, accept → ONE; `main` ← input.
  - ONE, accept & take → ONE; `main` ← input.
  - ONE, accept & no take → TWO; `skid` ← input.
  - ONE, no accept & take → EMPTY.
  - ONE, otherwise → stays ONE, `main` holds.
  - TWO, take → ONE; `main` ← `skid`.
  - TWO, no take → stays TWO, both entries hold.
- Flush has priority over all other events:
  - Next state is EMPTY and both entries are invalidated.
  - A beat accepted in the flush cycle is consumed and discarded.
  - A beat taken downstream in the flush cycle counts as delivered.
- Entering EMPTY (by take or by flush) loads `out_inst` ← `NOP_INST` and `out_pc4` ← 0.
- `stall_cnt` rules:
  - Increments each cycle with `out_valid` & ~`out_ready`.
  - Saturates at all-ones.
  - Clears only on reset; flush does not clear it.
- Reset values: state EMPTY, `out_valid` = 0, `in_ready` = 1, `out_pc4` = 0, `out_inst` = `NOP_INST`, `stall_cnt` = 0. The skid contents are don't-care.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on the outputs after edge N when the stage was EMPTY or was drained that cycle.
- Sustained throughput is 1 beat/cycle while `out_ready` = 1.
- All outputs are registered. There is no combinational path from `in_*` or `out_ready` to any output; `in_ready` depends only on state.
- After `out_ready` drops, at most one extra beat is absorbed, into `skid`, before `in_ready` falls.
- `reset` asserted mid-transfer clears everything immediately and asynchronously. The first accept is allowed on the first rising edge after deassertion.
- The stall counter updates on the same edge as the state.

## Structure
- Shared package `pipe_pkg` holds:
  - the state encoding (`ST_EMPTY`, `ST_ONE`, `ST_TWO`);
  - the default `NOP_INST` constant;
  - the payload field widths, for reuse by later stages.
- Payload is handled as one concatenated vector of width `PC_W + INST_W`.
- One sub-module, `sat_counter` (parameter `CNT_W`; ports `clock`, `reset`, `inc`, `count`), implements the stall counter.

## Test plan
- Reset → `out_valid` = 0, `in_ready` = 1, `out_inst` = `NOP_INST`, `out_pc4` = 0, `stall_cnt` = 0.
- Streaming: `in_valid` = 1 and `out_ready` = 1, `in_inst` = 0x1000_0001, 0x1000_0002, …, `in_pc4` = 4, 8, … for 5 cycles → outputs identical one cycle later, no gaps, `in_ready` stays 1.
- Backpressure: `out_ready` = 0 while beats A (`in_pc4` = 4) and B (`in_pc4` = 8) are accepted → state TWO, `in_ready` = 0, `out_pc4` = 4, `stall_cnt` rising. Then `out_ready` = 1 → A then B delivered in order, with no duplicate or loss.
- Flush in state TWO with a beat C on the input → next cycle `out_valid` = 0, `out_inst` = `NOP_INST`, `in_ready` = 1; A, B and C are never delivered.
- Counter saturation: `CNT_W` = 4, hold a valid beat with `out_ready` = 0 for 20 cycles → `stall_cnt` = 15 and stays there.
- Asynchronous reset pulsed mid-stream between clock edges → outputs return to their reset values immediately; streaming resumes correctly after deassertion.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers (IF/ID now, ID/EX and EX/MEM later).
package pipe_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;

    // Default bubble instruction that decode sees on an invalid slot
    localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter; holds at all-ones, clears only on reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
    parameter int                CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc4,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PL_W = PC_W + INST_W;
    localparam logic [PL_W-1:0] NOP_PAYLOAD = {{PC_W{1'b0}}, NOP_INST};

    stage_state_t    state_p1, state_n;
    logic [PL_W-1:0] main_p1, main_n;
    logic [PL_W-1:0] skid_p1, skid_n;
    logic [PL_W-1:0] in_payload;
    logic            accept, take;

    assign in_payload = {in_pc4, in_inst};

    // Outputs are pure decodes of flops, so nothing combinational reaches them
    assign out_valid = (state_p1 != ST_EMPTY);
    assign in_ready  = (state_p1 != ST_TWO);
    assign out_pc4   = main_p1[PL_W-1:INST_W];
    assign out_inst  = main_p1[INST_W-1:0];

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_comb begin
        state_n = state_p1;
        main_n  = main_p1;
        skid_n  = skid_p1;
        if (flush) begin
            state_n = ST_EMPTY;
            main_n  = NOP_PAYLOAD;
        end else begin
            case (state_p1)
                ST_EMPTY: begin
                    if (accept) begin
                        state_n = ST_ONE;
                        main_n  = in_payload;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        main_n = in_payload;
                    end else if (accept) begin
                        state_n = ST_TWO;
                        skid_n  = in_payload;
                    end else if (take) begin
                        state_n = ST_EMPTY;
                        main_n  = NOP_PAYLOAD;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        state_n = ST_ONE;
                        main_n  = skid_p1;
                    end
                end
                default: begin
                    state_n = ST_EMPTY;
                    main_n  = NOP_PAYLOAD;
                end
            endcase
        end
    end

    // Stage p1: state and output-facing entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_p1 <= ST_EMPTY;
            main_p1  <= NOP_PAYLOAD;
        end else begin
            state_p1 <= state_n;
            main_p1  <= main_n;
        end
    end

    // Skid contents are only read in ST_TWO, so they need no reset
    always_ff @(posedge clock) begin
        skid_p1 <= skid_n;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush,
// counter saturation (CNT_W = 4) and asynchronous reset mid-stream.
module tb_pipe_stage_skid;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int CNT_W  = 4;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc4;
    logic [INST_W-1:0] in_inst;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc4;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_stage_skid #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc4    (in_pc4),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc4   (out_pc4),
        .out_inst  (out_inst),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".pc4"},   64'(out_pc4),   64'(pc));
        chk({tag, ".inst"},  64'(out_inst),  64'(inst));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pc4    = '0;
        in_inst   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset values
        #12;
        chk_out("reset", 1'b0, 32'h0, 32'h0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.stall", 64'(stall_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Streaming, five beats back to back
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_inst   = 32'h1000_0001;
        in_pc4    = 32'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("stream", 1'b1, 32'(4 * (i + 1)), 32'h1000_0001 + 32'(i));
            chk("stream.in_ready", 64'(in_ready), 64'd1);
            in_inst = 32'h1000_0002 + 32'(i);
            in_pc4  = 32'(4 * (i + 2));
        end
        in_valid = 1'b0;
        tick();
        chk_out("stream.drain", 1'b0, 32'h0, 32'h0);
        chk("stream.stall", 64'(stall_cnt), 64'd0);

        // Backpressure: A then B absorbed, then delivered in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc4    = 32'd4;
        in_inst   = 32'h0000_000A;
        tick();
        chk_out("bp.a", 1'b1, 32'd4, 32'hA);
        chk("bp.a.in_ready", 64'(in_ready), 64'd1);
        chk("bp.a.stall", 64'(stall_cnt), 64'd0);
        in_pc4  = 32'd8;
        in_inst = 32'h0000_000B;
        tick();
        chk_out("bp.two", 1'b1, 32'd4, 32'hA);
        chk("bp.two.in_ready", 64'(in_ready), 64'd0);
        chk("bp.two.stall", 64'(stall_cnt), 64'd1);
        in_pc4  = 32'd12;
        in_inst = 32'h0000_000C;
        tick();
        chk_out("bp.hold", 1'b1, 32'd4, 32'hA);
        chk("bp.hold.in_ready", 64'(in_ready), 64'd0);
        chk("bp.hold.stall", 64'(stall_cnt), 64'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_out("bp.b", 1'b1, 32'd8, 32'hB);
        chk("bp.b.in_ready", 64'(in_ready), 64'd1);
        tick();
        chk_out("bp.empty", 1'b0, 32'h0, 32'h0);
        chk("bp.empty.stall", 64'(stall_cnt), 64'd2);

        // Flush in TWO with C waiting on the input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc4    = 32'd4;
        in_inst   = 32'h0000_000A;
        tick();
        in_pc4  = 32'd8;
        in_inst = 32'h0000_000B;
        tick();
        chk("fl.two.in_ready", 64'(in_ready), 64'd0);
        chk("fl.two.stall", 64'(stall_cnt), 64'd3);
        in_pc4  = 32'd12;
        in_inst = 32'h0000_000C;
        flush   = 1'b1;
        tick();
        chk_out("fl.after", 1'b0, 32'h0, 32'h0);
        chk("fl.after.in_ready", 64'(in_ready), 64'd1);
        chk("fl.after.stall", 64'(stall_cnt), 64'd4);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_out("fl.gone", 1'b0, 32'h0, 32'h0);

        // Saturation: one beat held with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc4    = 32'h40;
        in_inst   = 32'h0000_000D;
        tick();
        chk("sat.start", 64'(stall_cnt), 64'd4);
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat.cnt", 64'(stall_cnt), (4 + i > 15) ? 64'd15 : 64'(4 + i));
        end
        chk_out("sat.beat", 1'b1, 32'h40, 32'hD);

        // Async reset between edges while streaming
        out_ready = 1'b1;
        tick();
        chk_out("ar.drain", 1'b0, 32'h0, 32'h0);
        in_valid = 1'b1;
        in_pc4   = 32'h100;
        in_inst  = 32'h2000_0001;
        tick();
        chk_out("ar.pre", 1'b1, 32'h100, 32'h2000_0001);
        in_pc4  = 32'h104;
        in_inst = 32'h2000_0002;
        #3;
        reset = 1'b1;
        #1;
        chk_out("ar.mid", 1'b0, 32'h0, 32'h0);
        chk("ar.mid.in_ready", 64'(in_ready), 64'd1);
        chk("ar.mid.stall", 64'(stall_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk_out("ar.resume1", 1'b1, 32'h104, 32'h2000_0002);
        in_pc4  = 32'h108;
        in_inst = 32'h2000_0003;
        tick();
        chk_out("ar.resume2", 1'b1, 32'h108, 32'h2000_0003);
        in_valid = 1'b0;
        tick();
        chk_out("ar.end", 1'b0, 32'h0, 32'h0);
        chk("ar.end.stall", 64'(stall_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
